// File: rtl/dmem_responder_if.sv
// Request/response bundle between a pipeline memory stage and dmem_responder.
// Latency: none (pure wiring); the responder defines all timing.
// Backpressure: requester holds mem_rd_i/mem_wr_i until done_o; stall_o freezes the pipeline meanwhile.
// Optional err_o member is present only when DMEM_RESPONDER_ERR_EN is defined.
interface dmem_responder_if;
    logic [31:0] addr_i;
    logic [31:0] wr_data_i;
    logic        mem_wr_i;
    logic        mem_rd_i;
    logic [31:0] rd_data_o;
    logic        stall_o;
    logic        done_o;
`ifdef DMEM_RESPONDER_ERR_EN
    logic        err_o;

    // Pipeline side: drives requests, observes completion.
    modport master (
        output addr_i, wr_data_i, mem_wr_i, mem_rd_i,
        input  rd_data_o, stall_o, done_o, err_o
    );

    // Memory side: observes requests, drives completion.
    modport slave (
        input  addr_i, wr_data_i, mem_wr_i, mem_rd_i,
        output rd_data_o, stall_o, done_o, err_o
    );
`else
    // Pipeline side: drives requests, observes completion.
    modport master (
        output addr_i, wr_data_i, mem_wr_i, mem_rd_i,
        input  rd_data_o, stall_o, done_o
    );

    // Memory side: observes requests, drives completion.
    modport slave (
        input  addr_i, wr_data_i, mem_wr_i, mem_rd_i,
        output rd_data_o, stall_o, done_o
    );
`endif
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency word-addressed data memory answering one load/store at a time from the pipeline.
// Latency: request accepted in cycle 0 completes with a done_o pulse in cycle LATENCY (1..15).
// Backpressure: stall_o is high from acceptance until the response cycle; requests are held level.
// Optional feature: define DMEM_RESPONDER_ERR_EN to add err_o and suppress misaligned/out-of-range accesses.
module dmem_responder #(
    parameter int unsigned LATENCY     = 3,    // legal 1..15, fits the 4-bit counter
    parameter int unsigned DEPTH_WORDS = 256   // power of two, at least 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dmem_responder_if.slave bus
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
`ifdef DMEM_RESPONDER_ERR_EN
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    // An access is refused when it is not word aligned or falls beyond the array.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({1'b0, a} >= ADDR_LIMIT);
    endfunction
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic [31:0] mem_array [DEPTH_WORDS];

    logic             req;
    logic             enter_resp;
    logic             stall;
    logic             done;
    logic             acc_err;
    logic             mem_we;
    logic [IDX_W-1:0] acc_idx;

    assign req = bus.mem_rd_i | bus.mem_wr_i;

    // Next-state, counter and request-latch logic; stall/done decoded from the current state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        is_wr_d    = is_wr_q;
        enter_resp = 1'b0;
        stall      = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    stall     = 1'b1;
                    addr_d    = bus.addr_i;
                    wr_data_d = bus.wr_data_i;
                    // A simultaneous load and store is handled as a store.
                    is_wr_d   = bus.mem_wr_i;
                    cnt_d     = CNT_LOAD;
                    if (LATENCY > 1) begin
                        state_d = BUSY;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            BUSY: begin
                // Request inputs are not looked at here; the latched copy is authoritative.
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The access happens on the edge entering RESP; addr_d/wr_data_d/is_wr_d already hold the
    // request for that edge whether it arrives from IDLE (LATENCY==1) or from BUSY.
    always_comb begin
        acc_idx = IDX_W'(addr_d >> 2);  // drops byte offset, wraps upper bits modulo the depth
`ifdef DMEM_RESPONDER_ERR_EN
        acc_err = addr_bad(addr_d);
`else
        acc_err = 1'b0;
`endif
        // Reset on the same edge discards the pending store.
        mem_we    = enter_resp & is_wr_d & ~acc_err & ~rst_i;
        rd_data_d = rd_data_q;
        if (enter_resp && !is_wr_d) begin
            rd_data_d = acc_err ? 32'h0 : mem_array[acc_idx];
        end
    end

    // Control and load-data registers; reset returns to IDLE and clears the read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 32'h0;
            wr_data_q <= 32'h0;
            is_wr_q   <= 1'b0;
            rd_data_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            is_wr_q   <= is_wr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Backing array: no reset, contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_array[acc_idx] <= wr_data_d;
        end
    end

    assign bus.rd_data_o = rd_data_q;
    assign bus.stall_o   = stall;
    assign bus.done_o    = done;
`ifdef DMEM_RESPONDER_ERR_EN
    // Error flag accompanies done_o; addr_q still holds the request during RESP.
    assign bus.err_o     = done & addr_bad(addr_q);
`endif

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 3, cycles from request acceptance to response (legal range 1..15).
REQ-002 Parameter DEPTH_WORDS, default 256, number of 32-bit words in the backing array (power of two).
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 addr_i  input  32  byte address from the pipeline memory stage.
REQ-006 wr_data_i  input  32  store data.
REQ-007 mem_wr_i  input  1  store request, level, held by the requester until done_o.
REQ-008 mem_rd_i  input  1  load request, level, held by the requester until done_o.
REQ-009 rd_data_o  output  32  registered load data.
REQ-010 stall_o  output  1  pipeline freeze request to the hazard logic.
REQ-011 done_o  output  1  one-cycle completion pulse.

Function
REQ-012 FSM states: IDLE, BUSY, RESP; encoding is free.
REQ-013 IDLE: a request (mem_rd_i or mem_wr_i high) is accepted; addr_i, wr_data_i and type are latched, counter loads LATENCY-1; next state is BUSY if LATENCY>1, else RESP.
REQ-014 BUSY: counter decrements each cycle; on counter==1 the next state is RESP; request inputs are ignored.
REQ-015 On the edge entering RESP: a store writes latched data to word index addr[log2(DEPTH_WORDS)+1:2]; a load registers the array word into rd_data_o.
REQ-016 RESP lasts exactly one cycle, done_o=1, stall_o=0, then always returns to IDLE; requests in RESP are not sampled.
REQ-017 stall_o is combinational: high in IDLE while a request is present, high throughout BUSY, low in RESP and idle IDLE.
REQ-018 Request accepted at cycle 0 yields done_o at cycle LATENCY; stall_o high cycles 0..LATENCY-1.
REQ-019 mem_rd_i and mem_wr_i both high: treated as store; rd_data_o unchanged.
REQ-020 addr_i[1:0] ignored (word access); upper address bits beyond the array index wrap modulo DEPTH_WORDS.
REQ-021 rd_data_o holds its value until the next load completes; stores do not alter it.
REQ-022 Back-to-back: next request is accepted in the IDLE cycle following RESP; minimum request spacing LATENCY+1 cycles.

Reset
REQ-023 rst_i high at an edge: state IDLE, counter 0, rd_data_o 0, done_o 0; dominates all other activity.
REQ-024 Reset mid-operation (BUSY/RESP entry edge) discards the pending store; no array write occurs.
REQ-025 Array contents are not cleared by reset.

Configuration
REQ-026 Macro DMEM_RESPONDER_ERR_EN defined: adds output err_o (1 bit), high with done_o when the latched address is misaligned (addr[1:0]!=0) or addr_i >= 4*DEPTH_WORDS; an erroring store does not write, an erroring load returns 32'h0; err_o reset 0.
REQ-027 Macro undefined: no err_o port, wrap/ignore rules of REQ-020 apply, no error suppression.

Verification
REQ-028 LATENCY=3, store 0xDEADBEEF to 0x10 -> stall_o high cycles 0-2, done_o cycle 3; later load 0x10 -> rd_data_o=0xDEADBEEF at cycle 3.
REQ-029 LATENCY=1, back-to-back loads of 0x0 then 0x4 -> done_o at cycles 1 and 3, stall_o low on cycles 1 and 3.
REQ-030 Both mem_rd_i and mem_wr_i high, data 0x12345678 to 0x20 -> stored, rd_data_o unchanged; follow-up load returns 0x12345678.
REQ-031 rst_i asserted in BUSY of store 0xAAAA5555 to 0x8 -> IDLE next cycle, done_o never pulses, load 0x8 returns prior contents.
REQ-032 DEPTH_WORDS=256, store to 0x400 then load 0x0 -> returns stored value (wrap); with DMEM_RESPONDER_ERR_EN, same store -> err_o=1 with done_o, load 0x0 unchanged.
